// File: rtl/write_back_stage.sv
// write_back_stage: registered MEM/WB stage with write-back select.
// Aligns and extends sub-word loads, picks among memory, execute and link
// results, and drives the register-file write port one cycle later.
// Optional feature macro: WB_RETIRE_CNT_EN adds a 32-bit retire_cnt output.
module write_back_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_write,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic [DATA_W-1:0]     link_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]           retire_cnt,
`endif
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_out
);

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] sel_data;
  logic              capture_we;

  // Pick the addressed byte and halfword lanes out of the raw memory word
  always_comb begin
    byte_lane = mem_data[7:0];
    case (addr_lo)
      2'd0:    byte_lane = mem_data[7:0];
      2'd1:    byte_lane = mem_data[15:8];
      2'd2:    byte_lane = mem_data[23:16];
      default: byte_lane = mem_data[31:24];
    endcase
    half_lane = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
  end

  // Extend the selected lane to full width; word loads pass straight through
  always_comb begin
    load_data = mem_data;
    case (ld_size)
      2'd0: begin
        if (ld_signed)
          load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
        else
          load_data = {{(DATA_W-8){1'b0}}, byte_lane};
      end
      2'd1: begin
        if (ld_signed)
          load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
        else
          load_data = {{(DATA_W-16){1'b0}}, half_lane};
      end
      default: load_data = mem_data;
    endcase
  end

  // Final result select; encoding 3 aliases the execute result
  always_comb begin
    sel_data = ex_data;
    case (wb_sel)
      2'd0:    sel_data = load_data;
      2'd2:    sel_data = link_data;
      default: sel_data = ex_data;
    endcase
    capture_we = in_valid & reg_write & (rd_addr != '0);
  end

  // WB pipeline register: flush kills the slot, stall holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_out   <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      wb_we    <= capture_we;
      wb_addr  <= rd_addr;
      wb_out   <= sel_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count instructions that actually enter WB; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= '0;
    else if (in_valid & ~stall & ~flush)
      retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule
